// File: rtl/logic_unit_pipe_if.sv
// logic_unit_pipe_if: operand-in / result-out handshake bundle for logic_unit_pipe
interface logic_unit_pipe_if #(parameter int WIDTH = 32);
    localparam int CNTW = $clog2(WIDTH + 1);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [2:0]       sel;
    logic             acc_en;
    logic             acc_clr;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out;
    logic             zero;
    logic             parity;
    logic [CNTW-1:0]  ones;
    modport master (
        output in_valid, a, b, sel, acc_en, acc_clr, out_ready,
        input  in_ready, out_valid, out, zero, parity, ones
    );
    modport slave (
        input  in_valid, a, b, sel, acc_en, acc_clr, out_ready,
        output in_ready, out_valid, out, zero, parity, ones
    );
endinterface

// File: rtl/logic_unit_pipe.sv
// logic_unit_pipe: 2-stage valid/ready bitwise logic unit with chaining accumulator and result flags
module logic_unit_pipe #(
    parameter int WIDTH = 32
) (
    input logic              clk,
    input logic              rst_n,
    logic_unit_pipe_if.slave bus
);
    localparam int CNTW = $clog2(WIDTH + 1);

    logic             s1_valid_q, s2_valid_q;
    logic [WIDTH-1:0] a_q, b_q, acc_q, out_q;
    logic [2:0]       sel_q;
    logic             acc_en_q;
    logic             zero_q, parity_q;
    logic [CNTW-1:0]  ones_q;
    logic             s2_adv, in_fire, s2_load;
    logic [WIDTH-1:0] op_a, res_d;
    logic [CNTW-1:0]  ones_d;

    assign s2_adv        = !s2_valid_q || bus.out_ready;
    assign bus.in_ready  = !s1_valid_q || s2_adv;
    assign in_fire       = bus.in_valid && bus.in_ready;
    assign s2_load       = s2_adv && s1_valid_q;
    assign op_a          = acc_en_q ? acc_q : a_q;
    assign bus.out_valid = s2_valid_q;
    assign bus.out       = out_q;
    assign bus.zero      = zero_q;
    assign bus.parity    = parity_q;
    assign bus.ones      = ones_q;

    // stage-2 datapath: selected bitwise op on (A or accumulator, B) plus its popcount
    always_comb begin
        case (sel_q)
            3'b000:  res_d = op_a & b_q;
            3'b001:  res_d = op_a | b_q;
            3'b010:  res_d = op_a ^ b_q;
            3'b011:  res_d = ~op_a;
            3'b100:  res_d = ~b_q;
            3'b101:  res_d = ~(op_a & b_q);
            3'b110:  res_d = ~(op_a | b_q);
            default: res_d = ~(op_a ^ b_q);
        endcase
        ones_d = '0;
        for (int i = 0; i < WIDTH; i++) ones_d = ones_d + CNTW'(res_d[i]);
    end

    // stage 1: capture a transaction on input fire, empty when stage 2 takes it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            a_q        <= '0;
            b_q        <= '0;
            sel_q      <= '0;
            acc_en_q   <= 1'b0;
        end else if (in_fire) begin
            s1_valid_q <= 1'b1;
            a_q        <= bus.a;
            b_q        <= bus.b;
            sel_q      <= bus.sel;
            acc_en_q   <= bus.acc_en;
        end else if (s2_adv) begin
            s1_valid_q <= 1'b0;
        end
    end

    // stage 2: register result and flags; they hold while downstream stalls or the pipe is empty
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid_q <= 1'b0;
            out_q      <= '0;
            zero_q     <= 1'b1;
            parity_q   <= 1'b0;
            ones_q     <= '0;
        end else if (s2_adv) begin
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                out_q    <= res_d;
                zero_q   <= ~|res_d;
                parity_q <= ^res_d;
                ones_q   <= ones_d;
            end
        end
    end

    // accumulator follows every stage-2 result; a clear pulse overrides a same-cycle load
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) acc_q <= '0;
        else if (bus.acc_clr) acc_q <= '0;
        else if (s2_load) acc_q <= res_d;
    end
endmodule

// File: tb/tb_logic_unit_pipe.sv
// tb_logic_unit_pipe: directed vectors on a 32-bit and an 8-bit instance, plus randomized 8-bit run against a reference
module tb_logic_unit_pipe;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int checks = 0;
    int failures = 0;
    always #5 clk = ~clk;

    logic_unit_pipe_if #(.WIDTH(32)) u ();
    logic_unit_pipe_if #(.WIDTH(8))  v ();
    logic_unit_pipe #(.WIDTH(32)) dut32 (.clk(clk), .rst_n(rst_n), .bus(u));
    logic_unit_pipe #(.WIDTH(8))  dut8  (.clk(clk), .rst_n(rst_n), .bus(v));

    logic [31:0] q32[$];
    logic [7:0]  q8[$];
    logic        f32, f8;
    logic [7:0]  macc;
    logic [31:0] t2[8] = '{32'hA0A0A0A0, 32'hFAFAFAFA, 32'h5A5A5A5A, 32'h0F0F0F0F,
                           32'h55555555, 32'h5F5F5F5F, 32'h05050505, 32'hA5A5A5A5};

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] ref8(input logic [2:0] s, input logic [7:0] x, input logic [7:0] y);
        case (s)
            3'd0: return x & y;
            3'd1: return x | y;
            3'd2: return x ^ y;
            3'd3: return ~x;
            3'd4: return ~y;
            3'd5: return ~(x & y);
            3'd6: return ~(x | y);
            default: return ~(x ^ y);
        endcase
    endfunction

    // drive one cycle on the 32-bit bus; e is the hand-computed result queued if the input is accepted
    task automatic put32(input logic iv, input logic orr, input logic [2:0] s, input logic [31:0] x,
                         input logic [31:0] y, input logic ae, input logic clr, input logic [31:0] e);
        logic [31:0] e0;
        u.in_valid = iv; u.out_ready = orr; u.sel = s; u.a = x; u.b = y; u.acc_en = ae; u.acc_clr = clr;
        #1;
        if (u.out_valid && u.out_ready) begin
            if (q32.size() == 0) chk("sb32_extra", 64'(q32.size()), 64'd1);
            else begin
                e0 = q32.pop_front();
                chk("sb32", {u.out, u.zero, u.parity, u.ones}, {e0, e0 == 32'h0, ^e0, 6'($countones(e0))});
            end
        end
        f32 = u.in_valid && u.in_ready;
        if (f32) q32.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic idle32(input int n);
        repeat (n) put32(1'b0, 1'b1, 3'd0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
    endtask

    // drive one cycle on the 8-bit bus; accepted inputs are scored by the reference model
    task automatic put8(input logic iv, input logic orr, input logic [2:0] s, input logic [7:0] x,
                        input logic [7:0] y, input logic ae);
        logic [7:0] e;
        v.in_valid = iv; v.out_ready = orr; v.sel = s; v.a = x; v.b = y; v.acc_en = ae; v.acc_clr = 1'b0;
        #1;
        if (v.out_valid && v.out_ready) begin
            if (q8.size() == 0) chk("sb8_extra", 64'(q8.size()), 64'd1);
            else begin
                e = q8.pop_front();
                chk("sb8", {v.out, v.zero, v.parity, v.ones}, {e, e == 8'h0, ^e, 4'($countones(e))});
            end
        end
        f8 = v.in_valid && v.in_ready;
        if (f8) begin
            e = ref8(s, ae ? macc : x, y);
            macc = e;
            q8.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        logic [31:0] hold, x;
        u.in_valid = 1'b0; u.out_ready = 1'b0; u.sel = 3'd0; u.a = '0; u.b = '0; u.acc_en = 1'b0; u.acc_clr = 1'b0;
        v.in_valid = 1'b0; v.out_ready = 1'b0; v.sel = 3'd0; v.a = '0; v.b = '0; v.acc_en = 1'b0; v.acc_clr = 1'b0;
        macc = 8'h0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", u.out_valid, 1'b0);
        chk("rst_out", u.out, 32'h0);
        chk("rst_flags", {u.zero, u.parity, u.ones}, {1'b1, 1'b0, 6'd0});
        chk("rst8_flags", {v.out_valid, v.zero, v.ones}, {1'b0, 1'b1, 4'd0});
        rst_n = 1'b1;
        chk("rst_in_ready", u.in_ready, 1'b1);

        // all eight ops back-to-back
        for (int i = 0; i < 8; i++) begin
            put32(1'b1, 1'b1, 3'(i), 32'hF0F0F0F0, 32'hAAAAAAAA, 1'b0, 1'b0, t2[i]);
            chk("ops_accept", f32, 1'b1);
            if (i == 0) chk("ops_latency", u.out_valid, 1'b0);
            else chk("ops_out", {u.out_valid, u.out}, {1'b1, t2[i-1]});
            if (i == 1) chk("and_flags", {u.zero, u.parity, u.ones}, {1'b0, 1'b0, 6'd8});
        end
        idle32(3);
        chk("ops_drain", 64'(q32.size()), 64'd0);

        // reset with two transactions in flight
        put32(1'b1, 1'b1, 3'd0, 32'hF0F0F0F0, 32'hAAAAAAAA, 1'b0, 1'b0, 32'hA0A0A0A0);
        put32(1'b1, 1'b1, 3'd2, 32'hF0F0F0F0, 32'hAAAAAAAA, 1'b0, 1'b0, 32'h5A5A5A5A);
        rst_n = 1'b0;
        #1;
        chk("mid_out_valid", u.out_valid, 1'b0);
        chk("mid_out", u.out, 32'h0);
        chk("mid_flags", {u.zero, u.parity, u.ones}, {1'b1, 1'b0, 6'd0});
        q32.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("mid_in_ready", u.in_ready, 1'b1);
        put32(1'b1, 1'b1, 3'd3, 32'h0, 32'h0, 1'b1, 1'b0, 32'hFFFFFFFF);
        idle32(3);
        chk("mid_acc_cleared", u.out, 32'hFFFFFFFF);

        // backpressure: 5 stalled cycles with 3 offers
        n = 0;
        for (int c = 0; c < 5; c++) begin
            x = 32'h11111111 * (n + 1);
            put32(1'b1, 1'b0, 3'd1, x, 32'h0, 1'b0, 1'b0, x);
            if (f32) n++;
            if (c == 2) hold = u.out;
        end
        chk("bp_accepted", 64'(n), 64'd2);
        chk("bp_in_ready", u.in_ready, 1'b0);
        chk("bp_out_stable", {u.out_valid, u.out}, {1'b1, hold});
        for (int c = 0; c < 10 && n < 3; c++) begin
            put32(1'b1, 1'b1, 3'd1, 32'h33333333, 32'h0, 1'b0, 1'b0, 32'h33333333);
            if (f32) n++;
        end
        chk("bp_third", 64'(n), 64'd3);
        idle32(4);
        chk("bp_drain", 64'(q32.size()), 64'd0);

        // accumulator chain
        put32(1'b0, 1'b1, 3'd0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h0);
        put32(1'b1, 1'b1, 3'd1, 32'hFFFFFFFF, 32'h0000000F, 1'b1, 1'b0, 32'h0000000F);
        put32(1'b1, 1'b1, 3'd2, 32'hFFFFFFFF, 32'h000000FF, 1'b1, 1'b0, 32'h000000F0);
        put32(1'b1, 1'b1, 3'd3, 32'h0, 32'h12345678, 1'b1, 1'b0, 32'hFFFFFF0F);
        idle32(3);
        chk("chain_out", u.out, 32'hFFFFFF0F);
        chk("chain_flags", {u.zero, u.parity, u.ones}, {1'b0, 1'b0, 6'd28});
        chk("chain_drain", 64'(q32.size()), 64'd0);

        // accumulator clear colliding with a stage-2 load
        put32(1'b1, 1'b1, 3'd1, 32'h12345678, 32'h0, 1'b0, 1'b0, 32'h12345678);
        put32(1'b1, 1'b1, 3'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b1, 32'h0);
        chk("clr_out", u.out, 32'h12345678);
        idle32(3);
        chk("clr_result", {u.out, u.zero, u.ones}, {32'h0, 1'b1, 6'd0});
        chk("clr_drain", 64'(q32.size()), 64'd0);

        // 8-bit instance: directed XNOR then randomized traffic
        put8(1'b1, 1'b1, 3'd1, 8'hC3, 8'h3C, 1'b0);
        put8(1'b1, 1'b1, 3'd7, 8'hC3, 8'h3C, 1'b0);
        chk("x8_accept", f8, 1'b1);
        repeat (3) put8(1'b0, 1'b1, 3'd0, 8'h0, 8'h0, 1'b0);
        chk("x8_xnor", {v.out, v.zero, v.parity, v.ones}, {8'h00, 1'b1, 1'b0, 4'd0});
        n = 0;
        for (int c = 0; c < 40000 && n < 10000; c++) begin
            put8($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)),
                 8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)));
            if (f8) n++;
        end
        chk("rnd_count", 64'(n), 64'd10000);
        repeat (4) put8(1'b0, 1'b1, 3'd0, 8'h0, 8'h0, 1'b0);
        chk("rnd_drain", 64'(q8.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
